// File: rtl/simple_dpram_sclk_if.sv
// Bus bundle for simple_dpram_sclk: one write port, one read port.
interface simple_dpram_sclk_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  re;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  we;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output raddr, re, waddr, we, din,
        input  dout
    );

    modport slave (
        input  raddr, re, waddr, we, din,
        output dout
    );
endinterface

// File: rtl/simple_dpram_sclk.sv
// Single-clock simple dual-port RAM, registered read, optional write bypass.
// SIMPLE_DPRAM_OUTREG_EN adds a second output register (2-cycle read).
module simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    simple_dpram_sclk_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (ADDR_WIDTH < 1) begin : g_bad_aw
        $error("simple_dpram_sclk: ADDR_WIDTH must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_dw
        $error("simple_dpram_sclk: DATA_WIDTH must be >= 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  byp_q;
    logic                  coll_d;
    logic [DATA_WIDTH-1:0] rmux_d;

    assign coll_d = (ENABLE_BYPASS != 0) && bus.we &&
                    (bus.raddr == bus.waddr);

    always_ff @(posedge clk) begin
        if (rst_n && bus.we) begin
            mem_q[bus.waddr] <= bus.din;
        end
    end

    // Read-first array access; collisions are served from wdata_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            wdata_q <= '0;
            byp_q   <= 1'b0;
        end else if (bus.re) begin
            rdata_q <= mem_q[bus.raddr];
            byp_q   <= coll_d;
            if (coll_d) begin
                wdata_q <= bus.din;
            end
        end
    end

    assign rmux_d = byp_q ? wdata_q : rdata_q;

`ifdef SIMPLE_DPRAM_OUTREG_EN
    logic                  re_q;
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_q  <= 1'b0;
            out_q <= '0;
        end else begin
            re_q <= bus.re;
            if (re_q) begin
                out_q <= rmux_d;
            end
        end
    end

    assign bus.dout = out_q;
`else
    assign bus.dout = rmux_d;
`endif
endmodule

// File: tb/tb_simple_dpram_sclk.sv
// Directed bench: runs a bypass and a read-first instance side by side.
module tb_simple_dpram_sclk;
`ifdef SIMPLE_DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   nerr;
    int   nchk;

    simple_dpram_sclk_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if1 ();
    simple_dpram_sclk_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if0 ();

    assign if0.raddr = if1.raddr;
    assign if0.re    = if1.re;
    assign if0.waddr = if1.waddr;
    assign if0.we    = if1.we;
    assign if0.din   = if1.din;

    simple_dpram_sclk #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .ENABLE_BYPASS(1)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    simple_dpram_sclk #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .ENABLE_BYPASS(0)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic [3:0] ra,
                         input logic we, input logic [3:0] wa,
                         input logic [7:0] d);
        if1.re    = re;
        if1.raddr = ra;
        if1.we    = we;
        if1.waddr = wa;
        if1.din   = d;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        drive(1'b0, 4'd0, 1'b1, a, d);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [7:0] e1, input logic [7:0] e0);
        drive(1'b1, a, 1'b0, 4'd0, 8'h00);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < LAT - 1; i++) step();
        chk({tag, "_byp"}, if1.dout, e1);
        chk({tag, "_rf"}, if0.dout, e0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        logic [3:0] idx;
        nerr = 0;
        nchk = 0;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        step();
        step();
        chk("por_byp", if1.dout, 8'h00);
        chk("por_rf", if0.dout, 8'h00);
        rst_n = 1'b1;

        wr(4'd2, 8'h77);
        rd_chk("pre_rst", 4'd2, 8'h77, 8'h77);
        rst_n = 1'b0;
        drive(1'b1, 4'd2, 1'b1, 4'd2, 8'hEE);
        step();
        step();
        chk("rst_byp", if1.dout, 8'h00);
        chk("rst_rf", if0.dout, 8'h00);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        rd_chk("rst_keep", 4'd2, 8'h77, 8'h77);

        wr(4'd3, 8'hA5);
        wr(4'd4, 8'h3C);
        rd_chk("rd3", 4'd3, 8'hA5, 8'hA5);
        rd_chk("rd4", 4'd4, 8'h3C, 8'h3C);

        rd_chk("hold0", 4'd3, 8'hA5, 8'hA5);
        drive(1'b0, 4'd0, 1'b1, 4'd3, 8'hFF);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        chk("hold_byp", if1.dout, 8'hA5);
        chk("hold_rf", if0.dout, 8'hA5);
        rd_chk("hold_new", 4'd3, 8'hFF, 8'hFF);

        wr(4'd7, 8'h11);
        drive(1'b1, 4'd7, 1'b1, 4'd7, 8'h22);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < LAT - 1; i++) step();
        chk("coll_byp", if1.dout, 8'h22);
        chk("coll_rf", if0.dout, 8'h11);
        drive(1'b0, 4'd0, 1'b1, 4'd7, 8'h99);
        step();
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        chk("coll_hold", if1.dout, 8'h22);
        rd_chk("reread7", 4'd7, 8'h99, 8'h99);
        rd_chk("byp_clr", 4'd3, 8'hFF, 8'hFF);

        drive(1'b1, 4'd4, 1'b1, 4'd5, 8'h66);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < LAT - 1; i++) step();
        chk("nc_byp", if1.dout, 8'h3C);
        chk("nc_rf", if0.dout, 8'h3C);
        rd_chk("nc_wr", 4'd5, 8'h66, 8'h66);

        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            wr(idx, {4'h0, idx} ^ 8'h5A);
        end
        for (int k = 0; k < 18; k++) begin
            idx = 4'(k);
            drive(1'b1, idx, 1'b0, 4'd0, 8'h00);
            step();
            if (k >= LAT - 1) begin
                idx = 4'(k - LAT + 1);
                e = {4'h0, idx} ^ 8'h5A;
                chk($sformatf("sweep%0d", k), if1.dout, e);
                chk($sformatf("sweep%0d_rf", k), if0.dout, e);
            end
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
`ifdef SIMPLE_DPRAM_OUTREG_EN
        step();
        chk("sweep_tail", if1.dout, 8'h01 ^ 8'h5A);
        step();
        chk("sweep_hold", if1.dout, 8'h01 ^ 8'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/simple_dpram_sclk.md
Name: simple_dpram_sclk

Overview:
- Simple dual-port RAM on a single clock: one write port and one read port.
- Registered read with 1-cycle latency.
- Optional write-to-read bypass for same-address collisions, so the read returns the newly written data.
- Used as the storage array behind the synchronous FIFO; the FIFO drives its read/write pointers directly onto raddr/waddr.

Parameters:
- ADDR_WIDTH, default 4: address width; depth = 2**ADDR_WIDTH words; must be >= 1.
- DATA_WIDTH, default 8: word width in bits; must be >= 1.
- ENABLE_BYPASS, default 1: 1 = same-cycle write data is forwarded to a colliding read; 0 = colliding read returns the old memory contents.

Ports:
- clk  input  1  rising-edge clock for all logic.
- rst_n  input  1  synchronous active-low reset.
- raddr  input  ADDR_WIDTH  read address, sampled at the clk edge when re=1.
- re  input  1  read enable.
- waddr  input  ADDR_WIDTH  write address.
- we  input  1  write enable.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data, valid the cycle after a read.

Behaviour:
- Memory: array of 2**ADDR_WIDTH words of DATA_WIDTH bits, no reset.
  - Contents after power-up are undefined; the bench must not read unwritten locations.
- Write: at posedge clk with rst_n=1 and we=1, mem[waddr] <= din.
  - we is ignored while rst_n=0.
- Read: at posedge clk with rst_n=1 and re=1, the read register loads mem[raddr].
  - dout presents it from that edge on, i.e. 1-cycle latency.
- Hold: re=0 leaves dout unchanged indefinitely. Writes to the address last read do not alter dout until the next read.
- Reset: rst_n=0 at a clk edge clears the read register and the bypass state, so dout=0 from the following edge.
  - Memory contents are preserved across reset.
  - Reset mid-operation discards any read in flight; a write in that same cycle is dropped.
- Collision (re=1, we=1, raddr==waddr, same edge):
  - ENABLE_BYPASS=1: dout shows din of that cycle. Implementation is a registered copy of din plus a registered bypass flag muxed onto dout.
  - ENABLE_BYPASS=0: dout shows the pre-write memory word (read-first). The write still occurs.
- Non-colliding simultaneous read and write (different addresses): both proceed independently.
- Bypass flag: cleared by any read without a collision. It is only updated when re=1.
- Addresses wrap naturally within ADDR_WIDTH bits; no out-of-range condition exists.
- Parameter checks: ADDR_WIDTH<1 or DATA_WIDTH<1 raises a simulation error at elaboration.
- Area: no combinational path from inputs to dout; dout is driven from registers only (plus the bypass mux select, which is also registered).

Optional Feature:
- Macro: SIMPLE_DPRAM_OUTREG_EN.
- Defined: adds a second output pipeline register after the read/bypass mux. Read latency becomes 2 cycles.
  - The register advances only when the previous stage was loaded by a read, i.e. re delayed 1 cycle.
  - It is reset to 0 by rst_n like the first stage.
  - Hold and collision semantics are otherwise identical, just one cycle later.
- Undefined: single registered stage, 1-cycle latency as specified above.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with re=1, we=1 -> dout=0. Subsequent read of the written address returns its prior contents, not the din applied during reset.
- Basic write/read: write 0xA5 to addr 3, then 0x3C to addr 4; read addr 3, then addr 4 -> dout=0xA5 one cycle after the first read and 0x3C one cycle after the second.
- Hold: read addr 3 (0xA5), then re=0 for 5 cycles while writing 0xFF to addr 3 -> dout stays 0xA5. A new read of addr 3 returns 0xFF.
- Collision, ENABLE_BYPASS=1: mem[7]=0x11; same cycle we=1/waddr=7/din=0x22 and re=1/raddr=7 -> next-cycle dout=0x22. Re-read gives 0x22.
- Collision, ENABLE_BYPASS=0: same stimulus -> next-cycle dout=0x11; re-read of addr 7 gives 0x22.
- Full sweep with ADDR_WIDTH=4, DATA_WIDTH=8: write addr i with value i^0x5A for i=0..15, then read back with re every cycle -> dout sequence matches, including wrap from addr 15 to 0. Repeat with SIMPLE_DPRAM_OUTREG_EN defined and check 2-cycle latency.
